// File: rtl/rotate_pkg.sv
// Shared types and rotate helpers for left_rotate_engine.
// Optional right-rotate support is enabled by defining ROTATE_BIDIR_EN.
package rotate_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_AMT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } rot_state_t;

    // The word is doubled, shifted, and then one WIDTH-bit window is taken, so that no barrel mux is spelled out.
    function automatic logic [DEFAULT_WIDTH-1:0] rotl(
        input logic [DEFAULT_WIDTH-1:0] word,
        input logic [DEFAULT_AMT_W-1:0] s
    );
        logic [2*DEFAULT_WIDTH-1:0] dbl;
        dbl = {word, word} << s;
        return dbl[2*DEFAULT_WIDTH-1 -: DEFAULT_WIDTH];
    endfunction

    function automatic logic [DEFAULT_WIDTH-1:0] rotr(
        input logic [DEFAULT_WIDTH-1:0] word,
        input logic [DEFAULT_AMT_W-1:0] s
    );
        logic [2*DEFAULT_WIDTH-1:0] dbl;
        dbl = {word, word} >> s;
        return dbl[DEFAULT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/left_rotate_engine_if.sv
// Handshake bundle between the rotate engine (slave) and its user (master).
// The in_dir signal exists only when ROTATE_BIDIR_EN is defined.
interface left_rotate_engine_if
    import rotate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
`ifdef ROTATE_BIDIR_EN
    logic             in_dir;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, out_ready,
`ifdef ROTATE_BIDIR_EN
        output in_dir,
`endif
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
`ifdef ROTATE_BIDIR_EN
        input  in_dir,
`endif
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/left_rotate_engine_rot_step.sv
// Combinational rotate by 0..STEP positions. This is the only shifter the iterative engine needs.
// When ROTATE_BIDIR_EN is defined, dir=1 selects a right rotate.
module rot_step
    import rotate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = 1,
    localparam int SW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] word,
    input  logic [SW-1:0]    amt,
`ifdef ROTATE_BIDIR_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] left_cand [STEP+1];
`ifdef ROTATE_BIDIR_EN
    logic [WIDTH-1:0] right_cand [STEP+1];
`endif

    for (genvar gi = 0; gi <= STEP; gi++) begin : g_cand
        if (WIDTH == DEFAULT_WIDTH) begin : g_pkg
            assign left_cand[gi]  = rotl(word, DEFAULT_AMT_W'(gi));
`ifdef ROTATE_BIDIR_EN
            assign right_cand[gi] = rotr(word, DEFAULT_AMT_W'(gi));
`endif
        end else begin : g_generic
            logic [2*WIDTH-1:0] dbl_l;
            assign dbl_l         = {word, word} << gi;
            assign left_cand[gi] = dbl_l[2*WIDTH-1 -: WIDTH];
`ifdef ROTATE_BIDIR_EN
            logic [2*WIDTH-1:0] dbl_r;
            assign dbl_r          = {word, word} >> gi;
            assign right_cand[gi] = dbl_r[WIDTH-1:0];
`endif
        end
    end

    always_comb begin
        result = word;
        for (int i = 0; i <= STEP; i++) begin
            if (int'(amt) == i) begin
`ifdef ROTATE_BIDIR_EN
                result = dir ? right_cand[i] : left_cand[i];
`else
                result = left_cand[i];
`endif
            end
        end
    end

endmodule

// File: rtl/left_rotate_engine.sv
// Iterative rotate engine: it accepts a word and an amount, rotates by up to STEP bits per clock, and holds the result.
// When ROTATE_BIDIR_EN is defined, the engine also rotates right, using the latched in_dir.
module left_rotate_engine
    import rotate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    left_rotate_engine_if.slave bus
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam int SW    = $clog2(STEP + 1);

    rot_state_t       state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [AMT_W-1:0] remaining_reg, remaining_next;
    logic [SW-1:0]    step_amt;
    logic [WIDTH-1:0] step_result;
`ifdef ROTATE_BIDIR_EN
    logic             dir_reg, dir_next;
`endif

    // The final partial step is clipped so that remaining lands exactly on zero.
    always_comb begin
        if (int'(remaining_reg) >= STEP) step_amt = SW'(STEP);
        else                             step_amt = SW'(remaining_reg);
    end

    rot_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_rot_step (
        .word   (work_reg),
        .amt    (step_amt),
`ifdef ROTATE_BIDIR_EN
        .dir    (dir_reg),
`endif
        .result (step_result)
    );

    always_comb begin
        state_next     = state_reg;
        work_next      = work_reg;
        remaining_next = remaining_reg;
`ifdef ROTATE_BIDIR_EN
        dir_next       = dir_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    work_next      = bus.in_data;
                    remaining_next = bus.in_amt;
`ifdef ROTATE_BIDIR_EN
                    dir_next       = bus.in_dir;
`endif
                    state_next     = (bus.in_amt == '0) ? DONE : ROT;
                end
            end
            ROT: begin
                work_next      = step_result;
                remaining_next = remaining_reg - AMT_W'(step_amt);
                if (remaining_reg == AMT_W'(step_amt)) state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg      <= '0;
            remaining_reg <= '0;
`ifdef ROTATE_BIDIR_EN
            dir_reg       <= 1'b0;
`endif
        end else begin
            work_reg      <= work_next;
            remaining_reg <= remaining_next;
`ifdef ROTATE_BIDIR_EN
            dir_reg       <= dir_next;
`endif
        end
    end

    // Every output is taken directly from a register, so no input reaches an output combinationally.
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg == ROT) || (state_reg == DONE);
    assign bus.out_data  = work_reg;

endmodule

// File: doc/left_rotate_engine.md
# left_rotate_engine

Iterative, handshaked left cyclic-shift (rotate) engine for the SHA-256 datapath. It complements the existing combinational right-rotate helper. A word and a rotate amount are accepted on a valid/ready input port. The word is rotated left by up to STEP bit positions per clock, and the result is presented on a valid/ready output port until it is consumed. It sits between the message-schedule controller and any stage that needs a variable-amount rotate, trading latency for a smaller multiplexer tree.

## Interface
- WIDTH, 32, data word width in bits; must be a power of two ≥ 2.
- STEP, 1, maximum bit positions rotated per clock; must be a power of two with 1 ≤ STEP ≤ WIDTH.
- AMT_W (localparam), $clog2(WIDTH), width of the rotate amount.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream offers in_data/in_amt.
- in_ready  output  1  engine can accept; high only in IDLE.
- in_data  input  WIDTH  word to rotate.
- in_amt  input  AMT_W  rotate amount, 0..WIDTH-1.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream consumes the result.
- out_data  output  WIDTH  rotated word.
- busy  output  1  high in ROT or DONE.

## Operation
- FSM states are IDLE, ROT and DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, out_data=0. The internal remaining count is 0.
- IDLE: an accept occurs on a rising edge where in_valid && in_ready. On accept:
  - latch in_data into the working register;
  - set remaining to in_amt;
  - go to ROT if in_amt≠0, else go to DONE.
- ROT: on each edge, rotate the working register left by s = min(STEP, remaining) and subtract s from remaining. When remaining reaches 0, go to DONE.
- DONE: out_valid=1. out_data equals the working register and is held stable. On an edge with out_ready=1, return to IDLE.
- Arithmetic is modulo WIDTH. Bit i moves to bit (i+s) mod WIDTH. remaining never underflows.
- Inputs are ignored outside IDLE: in_valid and data changes while in ROT or DONE have no effect.
- Simultaneous events: in DONE, out_ready and in_valid in the same cycle consume only the output. The new input can be accepted at the earliest on the next edge, from IDLE.
- Reset mid-operation: asserting rst_n low in any state immediately forces IDLE and the reset values above. The in-flight word is discarded and no partial result is emitted.

## Timing
- Latency: out_valid rises ceil(in_amt/STEP) edges after the accepting edge. For in_amt=0, out_valid rises on the accepting edge itself.
- Throughput: one result per (ceil(in_amt/STEP) + 2) cycles when out_ready is held high.
- All outputs are registered, or are decoded only from the state register. There is no combinational path from any input to any output.

## Configuration
- Macro ROTATE_BIDIR_EN.
- Defined: adds the port in_dir (input, 1 bit), latched on accept. in_dir=0 rotates left; in_dir=1 rotates right, with bit i moving to bit (i−s) mod WIDTH. Latency and handshake rules are identical in both directions.
- Undefined: the in_dir port does not exist and the engine rotates left only.

## Structure
- Shared package rotate_pkg contains:
  - the state enum type (IDLE, ROT, DONE);
  - the default WIDTH constant;
  - pure functions rotl(word, s) and rotr(word, s).
- One sub-module, rot_step: combinational rotate of a WIDTH-bit word by 0..STEP positions, with direction input under ROTATE_BIDIR_EN. The top level holds the FSM, the remaining counter and the working register.

## Test plan
- STEP=1, in_data=0xF0000000, in_amt=4, out_ready=1 → out_data=0x0000000F, out_valid 4 edges after accept, asserted for one cycle.
- in_amt=0, in_data=0x12345678 → out_valid on the accepting edge, out_data=0x12345678.
- STEP=4, in_data=0x80000000, in_amt=31 → out_data=0x40000000 after 8 edges.
- Result pending with out_ready=0 for 10 cycles, in_valid toggling → out_data stable, in_ready=0, no new accept; on out_ready=1, return to IDLE.
- rst_n pulsed low during ROT → all outputs reset immediately. A following transaction (0x00000001, amt 31) yields 0x80000000.
- ROTATE_BIDIR_EN defined, in_dir=1, in_data=0xF0000000, in_amt=4 → out_data=0x0F000000.
